sort_word_collector: RTL and testbench
======================================

// Module: sort_word_collector
// PURPOSE
//   Upstream feeder for the 4x4-bit sorting network. Accepts a stream of 4-bit
//   elements over a valid/ready handshake and packs each group of ELEMS elements
//   into one 16-bit word. Each completed word is held in an output register and
//   presented over a second valid/ready handshake. out_data connects directly to
//   the sorter input.
// PARAMETERS
//   ELEM_W   4     width of one element, bits
//   ELEMS    4     elements per word; out_data width = ELEM_W*ELEMS = 16
//   PAD_VAL  4'h0  fill value for unused slots on flush; 0 sorts to the bottom
// PORTS
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous reset, active-high
//   in_valid   in   1   in_data is valid
//   in_ready   out  1   collector can take an element this cycle
//   in_data    in   4   element
//   out_valid  out  1   out_data holds a complete word
//   out_ready  in   1   downstream takes the word this cycle
//   out_data   out  16  packed word: 1st element [15:12], 2nd [11:8],
//                       3rd [7:4], 4th [3:0]
//   out_count  out  3   number of real (non-pad) elements in out_data, 1..4
//   flush      in   1   present only with COLLECT_FLUSH_EN; complete partial word
// BEHAVIOUR
//   - Reset (async, active-high): slot counter cnt=0, assembly register=0,
//     out_valid=0, out_data=0, out_count=0, flush_pend=0. in_ready=0 while rst=1.
//   - Input accept: in_valid & in_ready at a rising edge. The element is written
//     to slot cnt, then cnt increments.
//   - Word completes when the 4th element is accepted (cnt==3).
//     - If the output register is free (out_valid=0 or out_ready=1), the word
//       and out_count=4 load into the output register on that same edge;
//       out_valid=1 on the next cycle. Latency: 1 cycle from the last accept.
//     - cnt wraps to 0 and the assembly register clears to PAD_VAL slots.
//   - in_ready = ~rst & ~flush_pend & ~(cnt==3 & out_valid & ~out_ready).
//     Combinational on out_ready; no combinational path from in_valid.
//   - Output drain: out_valid & out_ready at an edge clears out_valid unless a
//     new word loads on the same edge. Back-to-back words sustain 1 elem/cycle.
//   - out_data and out_count are stable while out_valid=1 and out_ready=0.
//   - out_valid depends only on registers.
// CONFIGURATION
//   COLLECT_FLUSH_EN defined:
//     - flush port exists.
//     - flush=1 with cnt>0 (counting an element accepted the same cycle) sets
//       flush_pend.
//     - While flush_pend=1 and the output register is free: load the partial
//       word with empty slots = PAD_VAL, set out_count = number filled,
//       clear cnt and flush_pend.
//     - flush with cnt==0 and no accept is ignored.
//     - flush on the same edge as the 4th accept: normal full word, out_count=4,
//       no extra empty word.
//     - flush_pend is cleared by rst.
//   COLLECT_FLUSH_EN undefined:
//     - No flush port and no flush_pend logic (tie to 0).
//     - out_count is always 4 whenever out_valid=1.
// TESTING
//   1. Stream 3,9,1,F with out_ready=1 -> 1 cycle after 4th accept:
//      out_valid=1, out_data=16'h391F, out_count=4.
//   2. 8 elements 0..7 back-to-back, out_ready=1 -> words 16'h0123 then 16'h4567;
//      in_ready never drops.
//   3. Word held with out_ready=0, 4 more elements sent -> in_ready drops at cnt==3;
//      out_data stays 16'h0123; raise out_ready -> 16'h4567 follows, nothing lost.
//   4. rst pulsed mid-word after 2 accepts -> out_valid=0, out_data=0, cnt=0;
//      next 4 elements A,B,C,D give 16'hABCD.
//   5. (FLUSH_EN) accept 5,E then flush=1 -> out_data=16'h5E00, out_count=2.
//      flush with cnt==0 -> no word emitted.
//   6. (FLUSH_EN) flush on the same edge as 4th element 7 of 1,2,3,7 ->
//      exactly one word, 16'h1237, out_count=4.

Source files
------------

// File: rtl/sort_word_collector.sv
// sort_word_collector: packs groups of ELEMS elements into one word for the sorting network.
// Define COLLECT_FLUSH_EN to add a flush input that emits a PAD_VAL-filled partial word.
module sort_word_collector #(
    parameter int                ELEM_W  = 4,
    parameter int                ELEMS   = 4,
    parameter logic [ELEM_W-1:0] PAD_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
`ifdef COLLECT_FLUSH_EN
    input  logic                         flush,
`endif
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ELEM_W-1:0]            in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ELEM_W*ELEMS-1:0]      out_data,
    output logic [$clog2(ELEMS+1)-1:0]   out_count
);
    localparam int CW = $clog2(ELEMS);
    localparam int NW = $clog2(ELEMS + 1);
    localparam int DW = ELEM_W * ELEMS;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_asm, w_asm_next, r_out_data;
    logic [NW-1:0] r_out_count;
    logic          r_out_valid;
    logic          w_last, w_free, w_acc, w_full, w_flush_pend, w_flush_load;
    assign w_last       = r_cnt == CW'(ELEMS - 1);
    assign w_free       = ~r_out_valid | out_ready;
    assign in_ready     = ~rst & ~w_flush_pend & ~(w_last & r_out_valid & ~out_ready);
    assign w_acc        = in_valid & in_ready;
    assign w_full       = w_acc & w_last;
    assign w_flush_load = w_flush_pend & w_free;
    always_comb begin
        w_asm_next = r_asm;
        if (w_acc) w_asm_next[(ELEMS - 1 - int'(r_cnt)) * ELEM_W +: ELEM_W] = in_data;
    end
`ifdef COLLECT_FLUSH_EN
    logic r_flush_pend, w_flush_set;
    // A flush arriving with the completing accept is absorbed by that full word.
    assign w_flush_set = flush & ~r_flush_pend & ~w_full & ((r_cnt != '0) | w_acc);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_flush_pend <= 1'b0;
        else     r_flush_pend <= w_flush_set | (r_flush_pend & ~w_free);
    end
    assign w_flush_pend = r_flush_pend;
`else
    assign w_flush_pend = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_asm       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_count <= '0;
        end else if (w_full | w_flush_load) begin
            r_cnt       <= '0;
            r_asm       <= {ELEMS{PAD_VAL}};
            r_out_valid <= 1'b1;
            r_out_data  <= w_full ? w_asm_next : r_asm;
            r_out_count <= w_full ? NW'(ELEMS) : NW'(r_cnt);
        end else begin
            if (w_acc) begin
                r_cnt <= r_cnt + 1'b1;
                r_asm <= w_asm_next;
            end
            if (out_ready) r_out_valid <= 1'b0;
        end
    end
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_count = r_out_count;
endmodule

// File: tb/tb_sort_word_collector.sv
// tb_sort_word_collector: directed and random stimulus against a queue-based model of the collector.
// Flush scenarios are exercised when COLLECT_FLUSH_EN is defined.
module tb_sort_word_collector;
`ifdef COLLECT_FLUSH_EN
    localparam bit FL_EN = 1'b1;
`else
    localparam bit FL_EN = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [2:0]  out_count;
    int          nvec = 0;
    int          errs = 0;
    logic [3:0]  part[$];
    logic        m_valid = 1'b0;
    logic [15:0] m_data = '0;
    logic [2:0]  m_count = '0;
    logic        m_pend = 1'b0;

    sort_word_collector dut (
        .clk(clk), .rst(rst),
`ifdef COLLECT_FLUSH_EN
        .flush(flush),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_count(out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nvec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pack();
        logic [15:0] w = '0;
        for (int i = 0; i < 4; i++) w = (w << 4) | 16'(i < part.size() ? part[i] : 4'h0);
        return w;
    endfunction

    function automatic logic m_ready(input logic ordy);
        return !m_pend && !(part.size() == 3 && m_valid && !ordy);
    endfunction

    task automatic model_reset();
        part.delete();
        m_valid = 1'b0; m_data = '0; m_count = '0; m_pend = 1'b0;
    endtask

    // Drive one cycle's inputs, compare DUT against the model, then advance both one edge.
    task automatic step(input logic v, input logic [3:0] d, input logic ordy, input logic fl);
        logic acc, done, fl_e;
        in_valid = v; in_data = d; out_ready = ordy; flush = fl;
        #1;
        check("in_ready", 16'(in_ready), 16'(m_ready(ordy)));
        check("out_valid", 16'(out_valid), 16'(m_valid));
        if (m_valid) begin
            check("out_data", out_data, m_data);
            check("out_count", 16'(out_count), 16'(m_count));
        end
        fl_e = fl & FL_EN;
        acc  = v & m_ready(ordy);
        done = 1'b0;
        if (acc) part.push_back(d);
        if (part.size() == 4) begin
            m_data = pack(); m_count = 3'd4; m_valid = 1'b1; part.delete(); done = 1'b1;
        end else if (m_pend && (!m_valid || ordy)) begin
            m_data = pack(); m_count = 3'(part.size()); m_valid = 1'b1; part.delete();
            m_pend = 1'b0;
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        if (fl_e && !m_pend && !done && part.size() > 0) m_pend = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #1;
        check("rst_in_ready", 16'(in_ready), 16'h0);
        check("rst_out_valid", 16'(out_valid), 16'h0);
        check("rst_out_data", out_data, 16'h0);
        check("rst_out_count", 16'(out_count), 16'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        // single word 3,9,1,F
        step(1, 4'h3, 1, 0); step(1, 4'h9, 1, 0); step(1, 4'h1, 1, 0); step(1, 4'hF, 1, 0);
        check("t1_valid", 16'(out_valid), 16'h1);
        check("t1_data", out_data, 16'h391F);
        check("t1_count", 16'(out_count), 16'h4);
        step(0, 0, 1, 0);
        // eight elements back to back
        for (int i = 0; i < 8; i++) begin
            step(1, 4'(i), 1, 0);
            if (i == 3) check("t2_w0", out_data, 16'h0123);
        end
        check("t2_w1", out_data, 16'h4567);
        step(0, 0, 1, 0);
        // output held while the next word fills
        for (int i = 0; i < 7; i++) step(1, 4'(i), 0, 0);
        check("t3_in_ready_low", 16'(in_ready), 16'h0);
        step(1, 4'h7, 0, 0);
        check("t3_hold", out_data, 16'h0123);
        step(1, 4'h7, 1, 0);
        check("t3_next", out_data, 16'h4567);
        step(0, 0, 1, 0);
        // reset mid-word
        step(1, 4'h1, 1, 0); step(1, 4'h2, 1, 0);
        rst = 1'b1;
        #1;
        model_reset();
        check("t4_out_valid", 16'(out_valid), 16'h0);
        check("t4_out_data", out_data, 16'h0);
        check("t4_in_ready", 16'(in_ready), 16'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        step(1, 4'hA, 1, 0); step(1, 4'hB, 1, 0); step(1, 4'hC, 1, 0); step(1, 4'hD, 1, 0);
        check("t4_word", out_data, 16'hABCD);
        step(0, 0, 1, 0);
`ifdef COLLECT_FLUSH_EN
        step(1, 4'h5, 1, 0); step(1, 4'hE, 1, 0); step(0, 0, 1, 1); step(0, 0, 1, 0);
        check("t5_valid", 16'(out_valid), 16'h1);
        check("t5_data", out_data, 16'h5E00);
        check("t5_count", 16'(out_count), 16'h2);
        step(0, 0, 1, 1); step(0, 0, 1, 1); step(0, 0, 1, 0);
        check("t5_empty", 16'(out_valid), 16'h0);
        step(1, 4'h1, 1, 0); step(1, 4'h2, 1, 0); step(1, 4'h3, 1, 0); step(1, 4'h7, 1, 1);
        check("t6_data", out_data, 16'h1237);
        check("t6_count", 16'(out_count), 16'h4);
        step(0, 0, 1, 0); step(0, 0, 1, 0);
        check("t6_single", 16'(out_valid), 16'h0);
`endif
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 9) == 0));
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end
endmodule
